pipe_stall_sequencer: RTL and testbench

//  Central pipeline sequencer for the 4-stage-register CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 48 ++++
 rtl/pipe_perf_counter.sv | 26 ++
 rtl/pipe_stall_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pipe_stall_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: opcode constants, sequencer state encoding
// and the bundle of per-register enables/flushes driven by the sequencer.
package pipe_ctrl_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LD  = 4'b1000;
   localparam logic [3:0] OP_ST  = 4'b1001;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;

   localparam logic [1:0] ST_RUN_ENC      = 2'd0;
   localparam logic [1:0] ST_BR_WAIT_ENC  = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd2;
   localparam logic [1:0] ST_HALT_ENC     = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = ST_RUN_ENC,
      ST_BR_WAIT  = ST_BR_WAIT_ENC,
      ST_MEM_WAIT = ST_MEM_WAIT_ENC,
      ST_HALT     = ST_HALT_ENC
   } seq_state_t;

   typedef struct packed {
      logic pc_en;
      logic pc_sel_target;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_en;
   } pipe_ctrl_t;

   // Every register enable set to 'en', both flushes to 'flush', PC mux on sequential path.
   function automatic pipe_ctrl_t ctrl_uniform(input logic en, input logic flush);
      pipe_ctrl_t c;
      c.pc_en         = en;
      c.pc_sel_target = 1'b0;
      c.if_id_en      = en;
      c.if_id_flush   = flush;
      c.id_ex_en      = en;
      c.id_ex_flush   = flush;
      c.ex_mem_en     = en;
      c.mem_wb_en     = en;
      return c;
   endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter with synchronous clear; only built when PIPE_PERF_CNT_EN
// is defined, since nothing else instantiates it.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule
`endif

// File: rtl/pipe_stall_sequencer.sv
// Pipeline sequencer: arbitrates memory wait, halt, branch and load-use stalls into
// register enables/flushes and PC control. Optional counters via PIPE_PERF_CNT_EN.
module pipe_stall_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load_use_stall,
   input  logic i_id_is_branch,
   input  logic i_br_resolve,
   input  logic i_br_taken,
   input  logic i_mem_req,
   input  logic i_mem_ack,
   input  logic i_halt_req,
   output logic o_pc_en,
   output logic o_pc_sel_target,
   output logic o_if_id_en,
   output logic o_if_id_flush,
   output logic o_id_ex_en,
   output logic o_id_ex_flush,
   output logic o_ex_mem_en,
   output logic o_mem_wb_en,
   output logic o_mem_err,
   output logic o_halted
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_cycles,
   output logic [CNT_W-1:0] o_mem_wait_cycles
`endif
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

   seq_state_t      r_state;
   logic            r_ret_br;
   logic [TO_W-1:0] r_cnt;
   logic            r_mem_err;

   seq_state_t      w_next_state;
   logic            w_next_ret_br;
   logic [TO_W-1:0] w_next_cnt;
   logic            w_set_err;
   logic            w_halted;
   logic            w_mem_stall;
   pipe_ctrl_t      w_ctrl;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_RUN;
         r_ret_br  <= 1'b0;
         r_cnt     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_ret_br <= w_next_ret_br;
         r_cnt    <= w_next_cnt;
         if (w_set_err) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   assign w_mem_stall = i_mem_req && !i_mem_ack;

   // A memory miss outranks everything; halt and branch are only accepted from RUN.
   always_comb begin
      w_next_state  = r_state;
      w_next_ret_br = r_ret_br;
      w_next_cnt    = r_cnt;
      w_set_err     = 1'b0;
      w_halted      = 1'b0;
      w_ctrl        = ctrl_uniform(1'b0, 1'b0);

      if (i_rst) begin
         w_ctrl = ctrl_uniform(1'b0, 1'b1);
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_mem_stall) begin
                  w_next_state  = ST_MEM_WAIT;
                  w_next_ret_br = 1'b0;
                  w_next_cnt    = CNT_ONE;
               end else if (i_halt_req) begin
                  w_next_state = ST_HALT;
               end else if (i_id_is_branch) begin
                  w_ctrl             = ctrl_uniform(1'b1, 1'b0);
                  w_ctrl.pc_en       = 1'b0;
                  w_ctrl.if_id_flush = 1'b1;
                  w_next_state       = ST_BR_WAIT;
               end else if (i_load_use_stall) begin
                  w_ctrl             = ctrl_uniform(1'b1, 1'b0);
                  w_ctrl.pc_en       = 1'b0;
                  w_ctrl.if_id_en    = 1'b0;
                  w_ctrl.id_ex_flush = 1'b1;
               end else begin
                  w_ctrl = ctrl_uniform(1'b1, 1'b0);
               end
            end

            ST_BR_WAIT: begin
               if (w_mem_stall) begin
                  w_next_state  = ST_MEM_WAIT;
                  w_next_ret_br = 1'b1;
                  w_next_cnt    = CNT_ONE;
               end else begin
                  w_ctrl = ctrl_uniform(1'b1, 1'b1);
                  if (i_br_resolve) begin
                     w_ctrl.pc_sel_target = i_br_taken;
                     w_next_state         = ST_RUN;
                  end else begin
                     w_ctrl.pc_en = 1'b0;
                  end
               end
            end

            // A timeout is handled exactly like an ack, but leaves the sticky error behind.
            ST_MEM_WAIT: begin
               if (i_mem_ack || (r_cnt == TO_MAX)) begin
                  w_ctrl        = ctrl_uniform(1'b1, r_ret_br);
                  w_next_state  = r_ret_br ? ST_BR_WAIT : ST_RUN;
                  w_next_ret_br = 1'b0;
                  w_next_cnt    = '0;
                  w_set_err     = !i_mem_ack;
               end else begin
                  w_next_cnt = r_cnt + CNT_ONE;
               end
            end

            ST_HALT: begin
               w_halted = 1'b1;
               if (!i_halt_req) begin
                  w_next_state = ST_RUN;
               end
            end

            default: begin
               w_next_state = ST_RUN;
            end
         endcase
      end
   end

   assign o_pc_en         = w_ctrl.pc_en;
   assign o_pc_sel_target = w_ctrl.pc_sel_target;
   assign o_if_id_en      = w_ctrl.if_id_en;
   assign o_if_id_flush   = w_ctrl.if_id_flush;
   assign o_id_ex_en      = w_ctrl.id_ex_en;
   assign o_id_ex_flush   = w_ctrl.id_ex_flush;
   assign o_ex_mem_en     = w_ctrl.ex_mem_en;
   assign o_mem_wb_en     = w_ctrl.mem_wb_en;
   assign o_mem_err       = r_mem_err;
   assign o_halted        = w_halted;

`ifdef PIPE_PERF_CNT_EN
   logic w_stall_inc;
   logic w_flush_inc;
   logic w_mem_wait_inc;

   assign w_stall_inc    = !w_ctrl.pc_en && !w_halted;
   assign w_flush_inc    = w_ctrl.if_id_flush || w_ctrl.id_ex_flush;
   assign w_mem_wait_inc = (r_state == ST_MEM_WAIT);

   pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_rst),
      .i_inc   (w_stall_inc),
      .o_count (o_stall_cycles)
   );

   pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_rst),
      .i_inc   (w_flush_inc),
      .o_count (o_flush_cycles)
   );

   pipe_perf_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_rst),
      .i_inc   (w_mem_wait_inc),
      .o_count (o_mem_wait_cycles)
   );
`endif

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Scoreboard bench for pipe_stall_sequencer: a behavioural model queues the expected
// outputs per cycle and a negedge monitor compares them against the DUT.
module tb_pipe_stall_sequencer;

   localparam int MemTimeout = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic loadUseStall = 1'b0, idIsBranch = 1'b0, brResolve = 1'b0, brTaken = 1'b0;
   logic memReq = 1'b0, memAck = 1'b0, haltReq = 1'b0;
   logic pcEn, pcSelTarget, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn;
   logic memErr, halted;
`ifdef PIPE_PERF_CNT_EN
   logic [15:0] stallCycles, flushCycles, memWaitCycles;
`endif

   pipe_stall_sequencer #(.MEM_TIMEOUT(MemTimeout)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_load_use_stall (loadUseStall),
      .i_id_is_branch   (idIsBranch),
      .i_br_resolve     (brResolve),
      .i_br_taken       (brTaken),
      .i_mem_req        (memReq),
      .i_mem_ack        (memAck),
      .i_halt_req       (haltReq),
      .o_pc_en          (pcEn),
      .o_pc_sel_target  (pcSelTarget),
      .o_if_id_en       (ifIdEn),
      .o_if_id_flush    (ifIdFlush),
      .o_id_ex_en       (idExEn),
      .o_id_ex_flush    (idExFlush),
      .o_ex_mem_en      (exMemEn),
      .o_mem_wb_en      (memWbEn),
      .o_mem_err        (memErr),
      .o_halted         (halted)
`ifdef PIPE_PERF_CNT_EN
      ,
      .o_stall_cycles    (stallCycles),
      .o_flush_cycles    (flushCycles),
      .o_mem_wait_cycles (memWaitCycles)
`endif
   );

   typedef struct {
      logic [7:0] ctrl;
      logic       halted;
      logic       memErr;
      int         step;
   } expect_t;

   expect_t expQ[$];
   int numChecks = 0;
   int numErrors = 0;
   int stepNo = 0;

   // Model view: which waits are outstanding, not how the RTL encodes them.
   bit mHalted = 1'b0;
   bit mBranchPending = 1'b0;
   bit mBranchAfterMem = 1'b0;
   bit mErr = 1'b0;
   int mWaitBudget = 0;

   task automatic computeExpected(output expect_t e);
      bit pe, ps, ie, iflush, xe, xflush, me, we;
      pe = 0; ps = 0; ie = 0; iflush = 0; xe = 0; xflush = 0; me = 0; we = 0;
      e.halted = 1'b0;
      e.memErr = mErr;
      e.step   = stepNo;
      if (rst) begin
         iflush = 1; xflush = 1;
         mHalted = 0; mBranchPending = 0; mBranchAfterMem = 0; mErr = 0; mWaitBudget = 0;
      end else if (mWaitBudget != 0) begin
         if (memAck || mWaitBudget == 1) begin
            pe = 1; ie = 1; xe = 1; me = 1; we = 1;
            iflush = mBranchAfterMem; xflush = mBranchAfterMem;
            if (!memAck) mErr = 1;
            mBranchPending = mBranchAfterMem;
            mBranchAfterMem = 0;
            mWaitBudget = 0;
         end else begin
            mWaitBudget = mWaitBudget - 1;
         end
      end else if (mHalted) begin
         e.halted = 1'b1;
         if (!haltReq) mHalted = 0;
      end else if (mBranchPending) begin
         if (memReq && !memAck) begin
            mWaitBudget = MemTimeout; mBranchAfterMem = 1; mBranchPending = 0;
         end else begin
            ie = 1; xe = 1; me = 1; we = 1; iflush = 1; xflush = 1;
            if (brResolve) begin
               pe = 1; ps = brTaken; mBranchPending = 0;
            end
         end
      end else begin
         if (memReq && !memAck) begin
            mWaitBudget = MemTimeout; mBranchAfterMem = 0;
         end else if (haltReq) begin
            mHalted = 1;
         end else if (idIsBranch) begin
            ie = 1; iflush = 1; xe = 1; me = 1; we = 1; mBranchPending = 1;
         end else if (loadUseStall) begin
            xe = 1; xflush = 1; me = 1; we = 1;
         end else begin
            pe = 1; ie = 1; xe = 1; me = 1; we = 1;
         end
      end
      e.ctrl = {pe, ps, ie, iflush, xe, xflush, me, we};
   endtask

   task automatic applyStimulus(input logic r, input logic lus, input logic isBr,
                                input logic brRes, input logic brTk, input logic mReq,
                                input logic mAck, input logic hReq, input bit doCheck);
      expect_t e;
      @(posedge clk);
      #1;
      rst = r; loadUseStall = lus; idIsBranch = isBr; brResolve = brRes; brTaken = brTk;
      memReq = mReq; memAck = mAck; haltReq = hReq;
      stepNo++;
      computeExpected(e);
      if (doCheck) expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic checkOutput(input expect_t e);
      logic [7:0] act;
      act = {pcEn, pcSelTarget, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn};
      numChecks++;
      if (act !== e.ctrl) begin
         numErrors++;
         $display("[TB] FAIL ctrl step %0d: got %b expected %b", e.step, act, e.ctrl);
      end
      numChecks++;
      if (halted !== e.halted) begin
         numErrors++;
         $display("[TB] FAIL halted step %0d: got %b expected %b", e.step, halted, e.halted);
      end
      numChecks++;
      if (memErr !== e.memErr) begin
         numErrors++;
         $display("[TB] FAIL mem_err step %0d: got %b expected %b", e.step, memErr, e.memErr);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   initial begin
      logic h;
      $display("[TB] reset and idle");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);

      $display("[TB] load-use bubble");
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      $display("[TB] taken branch resolved two cycles later");
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1);
      idle(2);

      $display("[TB] memory wait acked after four cycles");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 1);
      idle(1);
`ifdef PIPE_PERF_CNT_EN
      numChecks++;
      if (memWaitCycles !== 16'd4) begin
         numErrors++;
         $display("[TB] FAIL mem_wait_cycles: got %0d expected 4", memWaitCycles);
      end
`endif
      idle(1);

      $display("[TB] memory timeout");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
      idle(20);

      $display("[TB] reset during memory wait inside branch wait");
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
      idle(2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1);
      idle(3);

      $display("[TB] halt request");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      $display("[TB] randomized traffic");
      h = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) < 6) h = ~h;
         applyStimulus($urandom_range(0, 99) < 2,
                       $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 40,
                       1'($urandom_range(0, 1)),
                       $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 35,
                       h, 1);
      end
      idle(2);

      @(negedge clk);
      #1;
      numChecks++;
      if (expQ.size() != 0) begin
         numErrors++;
         $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
      $finish;
   end

endmodule
